// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: controller states, skid depth and the
// read-issue admission rule.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SKID_DEPTH = 2;

  // A read may be issued only if its word will still have a skid slot when it lands.
  function automatic logic can_issue(logic [1:0] count, logic inflight, logic pop);
    logic [2:0] occ;
    // NOTE: blocking assignment is correct here: occ is a local temporary, not state.
    occ = {1'b0, count} + {2'b00, inflight} + 3'd1 - {2'b00, pop};
    return occ <= 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/bram_stream_reader_skid_fifo2.sv
// Two-entry first-word-fall-through skid buffer holding {last, data} words between the
// ram read port and the output stream.
module bram_stream_reader_skid_fifo2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents
  // are never observed and the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous ram region on start and emits it as a valid/ready stream, tagging the
// final word; a two-entry skid buffer absorbs the one-cycle read latency under back-pressure.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issue_cnt_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [1:0]            skid_count;
  logic [DATA_WIDTH:0]   skid_head;
  logic                  pop;
  logic                  abort_active;
  logic                  issue;
  logic                  issue_last;

  assign pop          = out_valid && out_ready;
  assign abort_active = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign issue_last   = (issue_cnt_q == len_q - CNT_ONE);
  assign issue        = (state_q == ST_RUN) && !abort && can_issue(skid_count, inflight_q, pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      raddr_q         <= '0;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      // The ram returns the issued word one cycle later; remember whether it is the last.
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      done_q          <= 1'b0;
      if (issue) begin
        raddr_q     <= raddr_q + ADDR_ONE;
        issue_cnt_q <= issue_cnt_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (length == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_RUN;
              raddr_q     <= base_addr;
              len_q       <= length;
              issue_cnt_q <= '0;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (issue && issue_last) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort || (pop && out_last)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  bram_stream_reader_skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (inflight_q),
    .data_i ({inflight_last_q, rdata}),
    .pop_i  (pop),
    .flush_i(abort_active),
    .data_o (skid_head),
    .count_o(skid_count)
  );

  assign raddr     = raddr_q;
  assign out_valid = (skid_count != 2'd0);
  assign out_data  = skid_head[DATA_WIDTH-1:0];
  assign out_last  = skid_head[DATA_WIDTH] && out_valid;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
